// File: rtl/alu_pkg.sv
// Shared ALU definitions: the ALU operation-select codes, the divide opcode
// encoding and the divide sequencer state type.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b1000;
    localparam logic [3:0] ALU_SLL   = 4'b0001;
    localparam logic [3:0] ALU_SLT   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b1010;
    localparam logic [3:0] ALU_PASSB = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SRA   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b1101;
    localparam logic [3:0] ALU_OR    = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b0111;

    // bit 1 selects remainder, bit 0 selects unsigned
    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ABS_A = 3'd1,
        ST_ABS_B = 3'd2,
        ST_ITER  = 3'd3,
        ST_FIX   = 3'd4,
        ST_DONE  = 3'd5
    } div_state_e;

endpackage

// File: rtl/alu_div_seq.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer. Owns no divider; it borrows the
// shared ALU (alu_req) and runs a restoring division, one quotient bit per
// cycle.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, op, dividend,       request (accepted only while ready)
//   divisor
//   flush                      synchronous abort
//   ready, busy, done, result  status and one-cycle result-valid pulse
//   alu_req, alu_a, alu_b,     borrowed-ALU request and operands
//   alu_sel
//   alu_f, alu_less            ALU result and unsigned borrow flag
//
// Build option: define ALU_DIV_CACHE_EN to keep the last computed
// quotient/remainder so a matching DIV/REM pair completes in two cycles.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | ready, waiting for start
// ST_ABS_A | |dividend| via ALU, or bypass cycle for special/cached
// ST_ABS_B | |divisor| via ALU
// ST_ITER  | 32 restoring-division steps
// ST_FIX   | apply sign to quotient or remainder, latch result
// ST_DONE  | done pulse
module alu_div_seq
    import alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ITER_CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            alu_req,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_sel,
    input  logic [XLEN-1:0] alu_f,
    input  logic            alu_less
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e            state, state_nx;
    div_op_e               op_q;
    logic                  a_neg, b_neg;
    logic [XLEN-1:0]       quo, rem, dvs;
    logic [ITER_CNT_W-1:0] cnt;
    logic                  skip;
    logic [XLEN-1:0]       skip_res;
    logic [XLEN-1:0]       rs;
    logic                  take;
    logic                  accept;
    logic                  div0, ovf;

    assign rs     = {rem[XLEN-2:0], quo[XLEN-1]};
    // rem[31] set means the shifted partial remainder is >= 2^32, so it
    // always exceeds the divisor even though the ALU sees only 32 bits.
    assign take   = rem[XLEN-1] | ~alu_less;
    assign accept = (state == ST_IDLE) && start && !flush;
    assign div0   = (divisor == '0);
    assign ovf    = !op[0] && (dividend == MIN_NEG) && (divisor == '1);

    assign ready  = (state == ST_IDLE);
    assign busy   = ~ready;
    assign done   = (state == ST_DONE);

`ifdef ALU_DIV_CACHE_EN
    logic            c_valid, c_uns;
    logic [XLEN-1:0] c_a, c_b, c_quo, c_rem, a_raw, b_raw;
    logic            hit;

    assign hit = c_valid && (dividend == c_a) && (divisor == c_b) && (op[0] == c_uns);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_valid <= 1'b0;
            c_uns   <= 1'b0;
            c_a     <= '0;
            c_b     <= '0;
            c_quo   <= '0;
            c_rem   <= '0;
            a_raw   <= '0;
            b_raw   <= '0;
        end else begin
            if (accept) begin
                a_raw <= dividend;
                b_raw <= divisor;
            end
            if (flush && state != ST_IDLE && state != ST_DONE) begin
                c_valid <= 1'b0;
            end else if (state == ST_FIX) begin
                c_valid <= 1'b1;
                c_uns   <= op_q[0];
                c_a     <= a_raw;
                c_b     <= b_raw;
                c_quo   <= (a_neg ^ b_neg) ? -quo : quo;
                c_rem   <= a_neg ? -rem : rem;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        alu_req  = 1'b0;
        alu_a    = '0;
        alu_b    = '0;
        alu_sel  = ALU_ADD;
        case (state)
            ST_IDLE: begin
                if (accept) state_nx = ST_ABS_A;
            end
            ST_ABS_A: begin
                if (skip) begin
                    state_nx = ST_DONE;
                end else begin
                    alu_req  = 1'b1;
                    alu_b    = quo;
                    alu_sel  = a_neg ? ALU_SUB : ALU_PASSB;
                    state_nx = ST_ABS_B;
                end
            end
            ST_ABS_B: begin
                alu_req  = 1'b1;
                alu_b    = dvs;
                alu_sel  = b_neg ? ALU_SUB : ALU_PASSB;
                state_nx = ST_ITER;
            end
            ST_ITER: begin
                alu_req = 1'b1;
                alu_a   = rs;
                alu_b   = dvs;
                alu_sel = ALU_SUB;
                if (cnt == '0) state_nx = ST_FIX;
            end
            ST_FIX: begin
                alu_req  = 1'b1;
                alu_b    = op_q[1] ? rem : quo;
                alu_sel  = (op_q[1] ? a_neg : (a_neg ^ b_neg)) ? ALU_SUB : ALU_PASSB;
                state_nx = ST_DONE;
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        if (flush && state != ST_IDLE) state_nx = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= DIV;
            a_neg    <= 1'b0;
            b_neg    <= 1'b0;
            quo      <= '0;
            rem      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            skip     <= 1'b0;
            skip_res <= '0;
            result   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q  <= div_op_e'(op);
                        a_neg <= !op[0] && dividend[XLEN-1];
                        b_neg <= !op[0] && divisor[XLEN-1];
                        quo   <= dividend;
                        dvs   <= divisor;
                        rem   <= '0;
                        cnt   <= '1;
                        if (div0) begin
                            skip     <= 1'b1;
                            skip_res <= op[1] ? dividend : '1;
                        end else if (ovf) begin
                            skip     <= 1'b1;
                            skip_res <= op[1] ? '0 : MIN_NEG;
`ifdef ALU_DIV_CACHE_EN
                        end else if (hit) begin
                            skip     <= 1'b1;
                            skip_res <= op[1] ? c_rem : c_quo;
`endif
                        end else begin
                            skip <= 1'b0;
                        end
                    end
                end
                ST_ABS_A: begin
                    if (skip) begin
                        if (!flush) result <= skip_res;
                    end else begin
                        quo <= alu_f;
                    end
                end
                ST_ABS_B: dvs <= alu_f;
                ST_ITER: begin
                    rem <= take ? alu_f : rs;
                    quo <= {quo[XLEN-2:0], take};
                    cnt <= cnt - ITER_CNT_W'(1);
                end
                ST_FIX: begin
                    if (!flush) result <= alu_f;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_div_seq.sv
module tb_alu_div_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        flush = 1'b0;
    logic        ready, busy, done, alu_req, alu_less;
    logic [31:0] result, alu_a, alu_b, alu_f;
    logic [3:0]  alu_sel;

    alu_div_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .dividend(dividend), .divisor(divisor), .flush(flush),
        .ready(ready), .busy(busy), .done(done), .result(result),
        .alu_req(alu_req), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_f(alu_f), .alu_less(alu_less)
    );

    always #5 clk = ~clk;

    // shared ALU stand-in
    always_comb begin
        case (alu_sel)
            ALU_ADD:   alu_f = alu_a + alu_b;
            ALU_SUB:   alu_f = alu_a - alu_b;
            ALU_PASSB: alu_f = alu_b;
            ALU_XOR:   alu_f = alu_a ^ alu_b;
            ALU_OR:    alu_f = alu_a | alu_b;
            ALU_AND:   alu_f = alu_a & alu_b;
            default:   alu_f = '0;
        endcase
        alu_less = (alu_a < alu_b);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] res;
        int          acc;
        int          lat;
        int          reqs;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail = 0;
    logic [31:0] last_exp = '0;
    bit          m_valid = 1'b0;
    logic [31:0] m_a = '0, m_b = '0;
    logic        m_uns = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        int   reqs = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (ready) reqs = 0;
            if (alu_req) reqs++;
            if (done) begin
                if (sb.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 with result %h, required no done", result);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_result"}, result, e.res);
                    chk({e.name, "_latency"}, cyc - e.acc, e.lat);
                    chk({e.name, "_alu_req_cycles"}, reqs, e.reqs);
                end
            end
        end
    endtask

    task automatic wait_ready(string name);
        int n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            n_assert++;
            n_fail++;
            $display("FAIL %s_ready_timeout: got ready=0 after %0d cycles, required ready=1", name, n);
        end
    endtask

    task automatic start_only(logic [1:0] o, logic [31:0] a, logic [31:0] b);
        op = o; dividend = a; divisor = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue(string name, logic [1:0] o, logic [31:0] a, logic [31:0] b,
                         logic [31:0] r, bit special);
        exp_t e;
        wait_ready(name);
        e.name = name;
        e.res  = r;
        e.acc  = cyc + 1;
        e.lat  = 35;
        e.reqs = 35;
        if (special) begin
            e.lat  = 1;
            e.reqs = 0;
        end
`ifdef ALU_DIV_CACHE_EN
        else if (m_valid && a == m_a && b == m_b && o[0] == m_uns) begin
            e.lat  = 1;
            e.reqs = 0;
        end
        if (!special) begin
            m_valid = 1'b1; m_a = a; m_b = b; m_uns = o[0];
        end
`endif
        sb.push_back(e);
        last_exp = r;
        start_only(o, a, b);
    endtask

    initial begin
        int n;
        #1;
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_alu_req", {31'b0, alu_req}, 32'd0);
        chk("rst_alu_sel", {28'b0, alu_sel}, {28'b0, ALU_ADD});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        fork monitor(); join_none
        @(negedge clk);

        issue("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 1'b0);
        issue("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 1'b0);
        issue("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        issue("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        issue("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0);
        issue("div_m100_m7", 2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 1'b0);
        issue("rem_m100_m7", 2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0);
        issue("div_5_0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
        issue("remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5, 1'b1);
        issue("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        issue("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);

        // start while busy must be ignored
        issue("divu_busy", 2'b01, 32'd12345, 32'd123, 32'd100, 1'b0);
        repeat (9) @(negedge clk);
        start_only(2'b01, 32'd9, 32'd3);

        // flush mid-iteration
        wait_ready("flush");
        start_only(2'b01, 32'd1000, 32'd10);
        repeat (7) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_ready", {31'b0, ready}, 32'd1);
        chk("flush_done", {31'b0, done}, 32'd0);
        chk("flush_result", result, last_exp);
        @(negedge clk);
        flush = 1'b0;
        m_valid = 1'b0;
        repeat (40) @(negedge clk);
        chk("flush_result_hold", result, last_exp);
        issue("divu_after_flush", 2'b01, 32'd12345, 32'd123, 32'd100, 1'b0);

        // asynchronous reset mid-iteration
        wait_ready("reset");
        start_only(2'b01, 32'd50, 32'd5);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", {31'b0, ready}, 32'd1);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_alu_req", {31'b0, alu_req}, 32'd0);
        chk("midrst_alu_a", alu_a, 32'd0);
        chk("midrst_alu_b", alu_b, 32'd0);
        chk("midrst_alu_sel", {28'b0, alu_sel}, {28'b0, ALU_ADD});
        @(negedge clk);
        rst_n = 1'b1;
        m_valid = 1'b0;
        @(negedge clk);
        issue("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 1'b0);

        issue("div_1000_m3", 2'b00, 32'd1000, 32'hFFFF_FFFD, 32'hFFFF_FEB3, 1'b0);
        issue("rem_1000_m3", 2'b10, 32'd1000, 32'hFFFF_FFFD, 32'd1, 1'b0);
        issue("divu_7_100", 2'b01, 32'd7, 32'd100, 32'd0, 1'b0);
        issue("remu_7_100", 2'b11, 32'd7, 32'd100, 32'd7, 1'b0);

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending results, required 0", sb.size());
        end
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
